piso_rr_sched: RTL and testbench

- Round-robin scheduler that shares one parallel-in/serial-out shift datapath between two requesters.
- Each requester presents a parallel word with a request. The block arbitrates, loads the winner's word, shifts it out MSB-first under a frame-valid strobe, then enforces an idle gap.
- Sits between word-producing blocks and a single serial output line.

---
 rtl/piso_rr_sched.sv | 148 ++++++++++++++
 tb/tb_piso_rr_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_rr_sched.sv
// piso_rr_sched: two-requester round-robin front end feeding one shared
// parallel-in/serial-out shifter. A granted word is shifted out MSB first
// under frame_valid, followed by GAP forced idle cycles.
module piso_rr_sched #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             serial_out,
    output logic             frame_valid,
    output logic             frame_src,
    output logic             busy
);

    localparam int CNT_W      = $clog2(WIDTH);
    localparam int GAP_W      = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               src_q, src_d;
    logic               last_q, last_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;

    logic               any_req;
    logic               winner;

    assign any_req = req0 | req1;

    // Arbitration: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_q;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    // Next-state and datapath update for the IDLE -> SHIFT -> GAP -> IDLE sequence.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        src_d     = src_q;
        last_d    = last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                src_d = 1'b0;
                if (any_req) begin
                    state_d   = ST_SHIFT;
                    shift_d   = winner ? data1 : data0;
                    bit_cnt_d = '0;
                    src_d     = winner;
                    last_d    = winner;
                    gnt0_d    = ~winner;
                    gnt1_d    = winner;
                end
            end

            ST_SHIFT: begin
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        src_d   = 1'b0;
                    end
                end
            end

            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                    src_d     = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                src_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset leaves the pointer so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            src_q     <= 1'b0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            src_q     <= src_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        frame_valid = (state_q == ST_SHIFT);
        serial_out  = (state_q == ST_SHIFT) & shift_q[WIDTH-1];
        busy        = (state_q != ST_IDLE);
        frame_src   = src_q;
        gnt0        = gnt0_q;
        gnt1        = gnt1_q;
    end

endmodule

// File: tb/tb_piso_rr_sched.sv
// Bench for piso_rr_sched: instance A (GAP=1) and instance B (GAP=0).
// Output vectors are packed as {gnt0, gnt1, serial_out, frame_valid, frame_src, busy}.
module tb_piso_rr_sched;

    localparam int W     = 4;
    localparam int GAP_A = 1;
    localparam int GAP_B = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         r0 [2];
    logic         r1 [2];
    logic [W-1:0] d0 [2];
    logic [W-1:0] d1 [2];

    logic g0_a, g1_a, so_a, fv_a, fs_a, bz_a;
    logic g0_b, g1_b, so_b, fv_b, fs_b, bz_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_rr_sched #(.WIDTH(W), .GAP(GAP_A)) dut_a (
        .clk(clk), .rst(rst),
        .req0(r0[0]), .data0(d0[0]), .req1(r1[0]), .data1(d1[0]),
        .gnt0(g0_a), .gnt1(g1_a), .serial_out(so_a),
        .frame_valid(fv_a), .frame_src(fs_a), .busy(bz_a)
    );

    piso_rr_sched #(.WIDTH(W), .GAP(GAP_B)) dut_b (
        .clk(clk), .rst(rst),
        .req0(r0[1]), .data0(d0[1]), .req1(r1[1]), .data1(d1[1]),
        .gnt0(g0_b), .gnt1(g1_b), .serial_out(so_b),
        .frame_valid(fv_b), .frame_src(fs_b), .busy(bz_b)
    );

    typedef struct {
        logic         rst_n;
        logic         q0;
        logic         q1;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [5:0]   exp;
    } vec_t;

    // Reference model: a frame accepted at the edge ending cycle c occupies
    // cycles c+1 .. c+W (data) and c+W+1 .. c+W+G (gap); IDLE again at c+1+W+G.
    typedef struct {
        int           cyc;
        int           fstart;
        int           idle_at;
        logic         last;
        logic         fsrc;
        logic [W-1:0] word;
    } model_t;

    vec_t       tbl [$];
    logic [5:0] exp_mr [6] = '{6'b101101, 6'b000101, 6'b001101, 6'b001101, 6'b000001, 6'b000000};

    function automatic vec_t mk(logic rn, logic q0, logic q1, logic [W-1:0] a, logic [W-1:0] b, logic [5:0] e);
        vec_t v;
        v.rst_n = rn; v.q0 = q0; v.q1 = q1; v.a = a; v.b = b; v.exp = e;
        return v;
    endfunction

    function automatic logic [5:0] outs(int i);
        if (i == 0) return {g0_a, g1_a, so_a, fv_a, fs_a, bz_a};
        return {g0_b, g1_b, so_b, fv_b, fs_b, bz_b};
    endfunction

    function automatic int gap_of(int i);
        return (i == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic model_t m_reset();
        model_t m;
        m.cyc = 0; m.fstart = -100; m.idle_at = 0;
        m.last = 1'b1; m.fsrc = 1'b0; m.word = '0;
        return m;
    endfunction

    function automatic logic [5:0] m_exp(model_t m, int g);
        int   k;
        logic sh, gp, b;
        k  = m.cyc - m.fstart;
        sh = (k >= 0) && (k < W);
        gp = (k >= W) && (k < W + g);
        b  = 1'b0;
        if (sh) b = m.word[W-1-k];
        return {sh && (k == 0) && !m.fsrc, sh && (k == 0) && m.fsrc, b, sh,
                (sh || gp) && m.fsrc, sh || gp};
    endfunction

    function automatic model_t m_step(model_t m, int g, logic q0, logic q1,
                                      logic [W-1:0] a, logic [W-1:0] b, output int won);
        won = -1;
        if (m.cyc >= m.idle_at && (q0 || q1)) begin
            if (q0 && q1) won = m.last ? 0 : 1;
            else          won = q0 ? 0 : 1;
            m.fstart  = m.cyc + 1;
            m.idle_at = m.cyc + 1 + W + g;
            m.last    = (won == 1);
            m.fsrc    = (won == 1);
            m.word    = (won == 1) ? b : a;
        end
        m.cyc++;
        return m;
    endfunction

    task automatic check6(string name, logic [5:0] act, logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; the cycle after return is post-reset cycle 0.
    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r0[i] = 1'b0; r1[i] = 1'b0; d0[i] = '0; d1[i] = '0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_t m [2];
        int     won [2];
        int     npulse;

        for (int i = 0; i < 2; i++) begin
            r0[i] = 1'b0; r1[i] = 1'b0; d0[i] = '0; d1[i] = '0;
        end

        // Reset and idle.
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'b000000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'b000000));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 6'b000000));
        // Single word 1011 from requester 0.
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'b1011, 4'h0, 6'b000000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1011, 4'h0, 6'b101101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1011, 4'h0, 6'b000101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1011, 4'h0, 6'b001101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1011, 4'h0, 6'b001101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1011, 4'h0, 6'b000001));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1011, 4'h0, 6'b000000));
        // Contention from reset: 1100 from src 0, then 0011 from src 1.
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'b000000));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 4'b1100, 4'b0011, 6'b000000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'b1100, 4'b0011, 6'b101101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'b1100, 4'b0011, 6'b001101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'b1100, 4'b0011, 6'b000101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'b1100, 4'b0011, 6'b000101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'b1100, 4'b0011, 6'b000001));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'b1100, 4'b0011, 6'b000000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1100, 4'b0011, 6'b010111));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1100, 4'b0011, 6'b000111));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1100, 4'b0011, 6'b001111));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1100, 4'b0011, 6'b001111));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1100, 4'b0011, 6'b000011));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1100, 4'b0011, 6'b000000));

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst   = tbl[i].rst_n;
            r0[0] = tbl[i].q0; r1[0] = tbl[i].q1;
            d0[0] = tbl[i].a;  d1[0] = tbl[i].b;
            @(negedge clk);
            check6($sformatf("vec%0d", i), outs(0), tbl[i].exp);
            check6($sformatf("vec%0d_b_idle", i), outs(1), 6'b000000);
            @(posedge clk); #1;
        end

        // Reset mid-frame after two bits, then a fresh full frame with req0 still high.
        do_reset();
        r0[0] = 1'b1; d0[0] = 4'b1011;
        @(negedge clk); check6("mr_idle", outs(0), 6'b000000);
        @(posedge clk); #1;
        @(negedge clk); check6("mr_bit0", outs(0), 6'b101101);
        @(posedge clk); #1;
        @(negedge clk); check6("mr_bit1", outs(0), 6'b000101);
        @(posedge clk); #1;
        @(negedge clk); check6("mr_bit2", outs(0), 6'b001101);
        #1 rst = 1'b0;
        #1 check6("mr_async_drop", outs(0), 6'b000000);
        @(posedge clk); #1; check6("mr_in_reset", outs(0), 6'b000000);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); check6("mr_re_idle", outs(0), 6'b000000);
        @(posedge clk); #1; r0[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); check6($sformatf("mr_refr%0d", i), outs(0), exp_mr[i]);
            @(posedge clk); #1;
        end

        // Fairness: both held high for six frames on instance A.
        do_reset();
        r0[0] = 1'b1; r1[0] = 1'b1; d0[0] = 4'b1010; d1[0] = 4'b0101;
        npulse = 0;
        for (int c = 0; c < 37; c++) begin
            @(negedge clk);
            if (g0_a || g1_a) begin
                check6($sformatf("fair_gnt%0d", npulse), {3'b000, g0_a, g1_a, fs_a},
                       {3'b000, (npulse % 2) == 0, (npulse % 2) == 1, (npulse % 2) == 1});
                npulse++;
            end
            @(posedge clk); #1;
        end
        check_int("fair_pulse_count", npulse, 6);
        r0[0] = 1'b0; r1[0] = 1'b0;

        // GAP=0 back-to-back on instance B with req1 held high.
        do_reset();
        r1[1] = 1'b1; d1[1] = 4'b1001;
        for (int c = 0; c < 15; c++) begin
            int         ph;
            logic       v, b;
            logic [W-1:0] pat;
            pat = 4'b1001;
            ph  = c % (W + 1);
            v   = (ph != 0);
            b   = 1'b0;
            if (v) b = pat[W-ph];
            @(negedge clk);
            check6($sformatf("gap0_c%0d", c), outs(1), {1'b0, ph == 1, b, v, v, v});
            @(posedge clk); #1;
        end
        r1[1] = 1'b0;

        // Randomised compliant requesters on both instances against the model.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            m[i]  = m_reset();
            r0[i] = ($urandom_range(0, 1) == 1); d0[i] = W'($urandom);
            r1[i] = ($urandom_range(0, 1) == 1); d1[i] = W'($urandom);
        end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check6($sformatf("rnd%0d_c%0d", i, c), outs(i), m_exp(m[i], gap_of(i)));
            @(posedge clk);
            for (int i = 0; i < 2; i++)
                m[i] = m_step(m[i], gap_of(i), r0[i], r1[i], d0[i], d1[i], won[i]);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (won[i] == 0) begin
                    r0[i] = ($urandom_range(0, 3) == 0); d0[i] = W'($urandom);
                end else if (!r0[i]) begin
                    r0[i] = ($urandom_range(0, 2) == 0); d0[i] = W'($urandom);
                end
                if (won[i] == 1) begin
                    r1[i] = ($urandom_range(0, 3) == 0); d1[i] = W'($urandom);
                end else if (!r1[i]) begin
                    r1[i] = ($urandom_range(0, 2) == 0); d1[i] = W'($urandom);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
